// File: rtl/tt_capture_pkg.sv
// Shared types and defaults for the truth-table capture engine.
// Holds the FSM state encodings and the default expected table.
package tt_capture_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int         N_IN_DEFAULT   = 3;
    localparam logic [7:0] TT_DEFAULT     = 8'b01100001;
    localparam int         SETTLE_DEFAULT = 2;
    localparam int         SETTLE_MAX     = 15;
    localparam int         CNT_W          = 4;

    // Out-of-range settle values are pinned to the nearest legal value.
    function automatic int settle_clamp(input int s);
        if (s < 1)
            return 1;
        else if (s > SETTLE_MAX)
            return SETTLE_MAX;
        else
            return s;
    endfunction

endpackage

// File: rtl/tt_capture.sv
// Sweeps every input vector onto an external combinational unit, samples its
// output after a settle delay and compares the captured table to EXPECTED.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for start; results of the last sweep are held
// ST_RUN  | driving x_out, counting settle cycles, sampling z_in at zero
module tt_capture
    import tt_capture_pkg::*;
#(
    parameter int                 N_IN     = N_IN_DEFAULT,
    parameter logic [2**N_IN-1:0] EXPECTED = TT_DEFAULT,
    parameter int                 SETTLE   = SETTLE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 z_in,
    output logic [N_IN-1:0]      x_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic [2**N_IN-1:0]   err_mask,
    output logic [N_IN:0]        err_cnt,
    output logic                 pass
);

    localparam int              TW     = 2**N_IN;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(settle_clamp(SETTLE) - 1);

    state_t            r_state;
    state_t            w_state_nx;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic [N_IN-1:0]   r_x;
    logic [N_IN-1:0]   w_x_nx;
    logic              r_busy;
    logic              w_busy_nx;
    logic              r_done;
    logic              w_done_nx;
    logic [TW-1:0]     r_table;
    logic [TW-1:0]     w_table_nx;
    logic [TW-1:0]     r_mask;
    logic [TW-1:0]     w_mask_nx;
    logic [N_IN:0]     r_err_cnt;
    logic [N_IN:0]     w_err_cnt_nx;
    logic              r_pass;
    logic              w_pass_nx;

    logic              w_miss;
    logic              w_last;
    logic [N_IN:0]     w_err_inc;

    assign w_miss    = z_in ^ EXPECTED[r_x];
    assign w_last    = (r_x == {N_IN{1'b1}});
    assign w_err_inc = r_err_cnt + {{N_IN{1'b0}}, w_miss};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_x_nx       = r_x;
        w_busy_nx    = r_busy;
        w_done_nx    = 1'b0;
        w_table_nx   = r_table;
        w_mask_nx    = r_mask;
        w_err_cnt_nx = r_err_cnt;
        w_pass_nx    = r_pass;

        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_state_nx   = ST_RUN;
                    w_cnt_nx     = RELOAD;
                    w_x_nx       = '0;
                    w_busy_nx    = 1'b1;
                    w_table_nx   = '0;
                    w_mask_nx    = '0;
                    w_err_cnt_nx = '0;
                    w_pass_nx    = 1'b0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // partial results stay visible; the pending sample is dropped
                    w_state_nx = ST_IDLE;
                    w_busy_nx  = 1'b0;
                    w_pass_nx  = 1'b0;
                end else if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - 1'b1;
                end else begin
                    w_table_nx[r_x] = z_in;
                    w_mask_nx[r_x]  = w_miss;
                    w_err_cnt_nx    = w_err_inc;
                    if (!w_last) begin
                        w_x_nx   = r_x + N_IN'(1);
                        w_cnt_nx = RELOAD;
                    end else begin
                        w_state_nx = ST_IDLE;
                        w_busy_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                        w_pass_nx  = (w_err_inc == '0);
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_x       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_table   <= '0;
            r_mask    <= '0;
            r_err_cnt <= '0;
            r_pass    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nx;
            r_x       <= w_x_nx;
            r_busy    <= w_busy_nx;
            r_done    <= w_done_nx;
            r_table   <= w_table_nx;
            r_mask    <= w_mask_nx;
            r_err_cnt <= w_err_cnt_nx;
            r_pass    <= w_pass_nx;
        end
    end

    assign x_out     = r_x;
    assign busy      = r_busy;
    assign done      = r_done;
    assign table_out = r_table;
    assign err_mask  = r_mask;
    assign err_cnt   = r_err_cnt;
    assign pass      = r_pass;

endmodule

// File: tb/tb_tt_capture.sv
// Bench for tt_capture: two instances (settle 2 and 3) drive a modelled unit
// under test; expected sweep results are queued and checked on completion.
module tb_tt_capture;

    typedef struct {
        logic [7:0] tbl;
        logic [7:0] msk;
        logic [3:0] cnt;
        logic       pss;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
    logic       z_a, z_b;
    logic [2:0] x_a, x_b;
    logic [2:0] d1_a = '0, d2_a = '0, d1_b = '0, d2_b = '0;
    logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [7:0] table_a, mask_a, table_b, mask_b;
    logic [3:0] cnt_a, cnt_b;
    logic [7:0] exp_tt = 8'h61;

    int   mode_a = 0, mode_b = 0;   // 0 correct, 1 stuck-at-0, 2 slow output
    int   m_last_x = 0;
    int   n_checks = 0, n_errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic f_ref(input logic [2:0] x);
        return x[2] ? (x[1] ^ x[0]) : ~(x[1] | x[0]);
    endfunction

    function automatic int pop8(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic exp_t mk_exp(input logic [7:0] obs, input int lat);
        exp_t e;
        e.tbl = obs;
        e.msk = obs ^ exp_tt;
        e.cnt = 4'(pop8(e.msk));
        e.pss = (e.cnt == 4'd0);
        e.lat = lat;
        return e;
    endfunction

    // slow unit: output follows the input two flops late
    always @(posedge clk) begin
        d1_a <= x_a; d2_a <= d1_a;
        d1_b <= x_b; d2_b <= d1_b;
    end
    assign z_a = (mode_a == 0) ? f_ref(x_a) : (mode_a == 1) ? 1'b0 : f_ref(d2_a);
    assign z_b = (mode_b == 0) ? f_ref(x_b) : (mode_b == 1) ? 1'b0 : f_ref(d2_b);

    tt_capture #(.N_IN(3), .EXPECTED(8'b01100001), .SETTLE(2)) u_dut (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .z_in(z_a),
        .x_out(x_a), .busy(busy_a), .done(done_a), .table_out(table_a),
        .err_mask(mask_a), .err_cnt(cnt_a), .pass(pass_a));

    tt_capture #(.N_IN(3), .EXPECTED(8'b01100001), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .z_in(z_b),
        .x_out(x_b), .busy(busy_b), .done(done_b), .table_out(table_b),
        .err_mask(mask_b), .err_cnt(cnt_b), .pass(pass_b));

    task automatic wait_done(input bit sel, input int maxc, output int edges);
        edges = 0;
        while (edges < maxc) begin
            @(posedge clk); #1;
            edges++;
            if ((sel ? done_b : done_a) === 1'b1) break;
        end
    endtask

    task automatic do_sweep(input bit sel, input int maxc, output int edges);
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        wait_done(sel, maxc, edges);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (x_a !== 3'd0) begin n_errors++; $display("FAIL reset_x: got %0d want 0", x_a); end
        n_checks++; if ({busy_a, done_a, pass_a} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b want 000", {busy_a, done_a, pass_a}); end
        n_checks++; if ({table_a, mask_a, cnt_a} !== 20'h0) begin n_errors++; $display("FAIL reset_results: got %h want 0", {table_a, mask_a, cnt_a}); end
        n_checks++; if ({busy_b, table_b, cnt_b} !== 13'h0) begin n_errors++; $display("FAIL reset_b: got %h want 0", {busy_b, table_b, cnt_b}); end
        m_last_x = 0;
    endtask

    task automatic test_correct();
        logic [7:0] obs; int edges; exp_t e;
        mode_a = 0;
        for (int i = 0; i < 8; i++) obs[i] = f_ref(3'(i));
        sb.push_back(mk_exp(obs, 16));
        do_sweep(1'b0, 40, edges);
        e = sb.pop_front();
        n_checks++; if (edges !== e.lat) begin n_errors++; $display("FAIL correct_latency: got %0d want %0d", edges, e.lat); end
        n_checks++; if (table_a !== e.tbl) begin n_errors++; $display("FAIL correct_table: got %h want %h", table_a, e.tbl); end
        n_checks++; if (mask_a !== e.msk) begin n_errors++; $display("FAIL correct_mask: got %h want %h", mask_a, e.msk); end
        n_checks++; if (cnt_a !== e.cnt) begin n_errors++; $display("FAIL correct_cnt: got %0d want %0d", cnt_a, e.cnt); end
        n_checks++; if (pass_a !== e.pss) begin n_errors++; $display("FAIL correct_pass: got %b want %b", pass_a, e.pss); end
        n_checks++; if ({busy_a, x_a} !== 4'b0111) begin n_errors++; $display("FAIL correct_busy_x: got %b want 0111", {busy_a, x_a}); end
        @(posedge clk); #1;
        n_checks++; if ({done_a, pass_a, table_a} !== {2'b01, e.tbl}) begin n_errors++; $display("FAIL done_pulse_hold: got %h want %h", {done_a, pass_a, table_a}, {2'b01, e.tbl}); end
        m_last_x = 7;
    endtask

    task automatic test_stuck();
        int edges; exp_t e;
        mode_a = 1;
        sb.push_back(mk_exp(8'h00, 16));
        do_sweep(1'b0, 40, edges);
        e = sb.pop_front();
        n_checks++; if (edges !== e.lat) begin n_errors++; $display("FAIL stuck_latency: got %0d want %0d", edges, e.lat); end
        n_checks++; if (table_a !== e.tbl) begin n_errors++; $display("FAIL stuck_table: got %h want %h", table_a, e.tbl); end
        n_checks++; if (mask_a !== e.msk) begin n_errors++; $display("FAIL stuck_mask: got %h want %h", mask_a, e.msk); end
        n_checks++; if (cnt_a !== e.cnt) begin n_errors++; $display("FAIL stuck_cnt: got %0d want %0d", cnt_a, e.cnt); end
        n_checks++; if (pass_a !== e.pss) begin n_errors++; $display("FAIL stuck_pass: got %b want %b", pass_a, e.pss); end
        m_last_x = 7;
    endtask

    task automatic test_settle();
        logic [7:0] obs; int edges; exp_t e;
        mode_a = 2;
        // with settle 2 each sample still sees the previous vector's output
        for (int i = 0; i < 8; i++) obs[i] = f_ref((i == 0) ? 3'(m_last_x) : 3'(i - 1));
        sb.push_back(mk_exp(obs, 16));
        do_sweep(1'b0, 40, edges);
        e = sb.pop_front();
        n_checks++; if (edges !== e.lat) begin n_errors++; $display("FAIL settle2_latency: got %0d want %0d", edges, e.lat); end
        n_checks++; if (table_a !== e.tbl) begin n_errors++; $display("FAIL settle2_table: got %h want %h", table_a, e.tbl); end
        n_checks++; if (cnt_a !== e.cnt) begin n_errors++; $display("FAIL settle2_cnt: got %0d want %0d", cnt_a, e.cnt); end
        n_checks++; if (pass_a !== e.pss) begin n_errors++; $display("FAIL settle2_pass: got %b want %b", pass_a, e.pss); end
        mode_a = 0;
        mode_b = 2;
        for (int i = 0; i < 8; i++) obs[i] = f_ref(3'(i));
        sb.push_back(mk_exp(obs, 24));
        do_sweep(1'b1, 50, edges);
        e = sb.pop_front();
        n_checks++; if (edges !== e.lat) begin n_errors++; $display("FAIL settle3_latency: got %0d want %0d", edges, e.lat); end
        n_checks++; if (table_b !== e.tbl) begin n_errors++; $display("FAIL settle3_table: got %h want %h", table_b, e.tbl); end
        n_checks++; if ({mask_b, cnt_b} !== {e.msk, e.cnt}) begin n_errors++; $display("FAIL settle3_mask_cnt: got %h want %h", {mask_b, cnt_b}, {e.msk, e.cnt}); end
        n_checks++; if (pass_b !== e.pss) begin n_errors++; $display("FAIL settle3_pass: got %b want %b", pass_b, e.pss); end
    endtask

    task automatic test_abort();
        exp_t e; bit seen;
        mode_a = 0;
        e.tbl = '0; e.msk = '0;
        for (int i = 0; i < 3; i++) begin
            e.tbl[i] = f_ref(3'(i));
            e.msk[i] = e.tbl[i] ^ exp_tt[i];
        end
        e.cnt = 4'(pop8(e.msk)); e.pss = 1'b0; e.lat = 7;
        sb.push_back(e);
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk); abort_a = 1'b1;
        @(posedge clk); #1; abort_a = 1'b0;
        e = sb.pop_front();
        n_checks++; if ({busy_a, done_a} !== 2'b00) begin n_errors++; $display("FAIL abort_flags: got %b want 00", {busy_a, done_a}); end
        n_checks++; if (x_a !== 3'd3) begin n_errors++; $display("FAIL abort_x: got %0d want 3", x_a); end
        n_checks++; if (table_a !== e.tbl) begin n_errors++; $display("FAIL abort_table: got %h want %h", table_a, e.tbl); end
        n_checks++; if ({mask_a, cnt_a, pass_a} !== {e.msk, e.cnt, e.pss}) begin n_errors++; $display("FAIL abort_mask_cnt_pass: got %h want %h", {mask_a, cnt_a, pass_a}, {e.msk, e.cnt, e.pss}); end
        seen = 1'b0;
        repeat (20) begin @(posedge clk); #1; if (done_a !== 1'b0 || busy_a !== 1'b0) seen = 1'b1; end
        n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL abort_no_done: got %b want 0", seen); end
        m_last_x = 3;
    endtask

    task automatic test_start_busy();
        logic [7:0] obs; int edges; exp_t e; bit stayed;
        mode_a = 0;
        for (int i = 0; i < 8; i++) obs[i] = f_ref(3'(i));
        sb.push_back(mk_exp(obs, 16));
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        edges = 0;
        while (edges < 40) begin
            @(posedge clk); #1;
            edges++;
            start_a = (edges == 5);
            if (done_a === 1'b1) break;
        end
        start_a = 1'b0;
        e = sb.pop_front();
        n_checks++; if (edges !== e.lat) begin n_errors++; $display("FAIL busy_start_latency: got %0d want %0d", edges, e.lat); end
        n_checks++; if ({table_a, pass_a} !== {e.tbl, e.pss}) begin n_errors++; $display("FAIL busy_start_result: got %h want %h", {table_a, pass_a}, {e.tbl, e.pss}); end
        @(negedge clk); start_a = 1'b1; abort_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0; abort_a = 1'b0;
        stayed = 1'b1;
        repeat (4) begin if (busy_a !== 1'b0) stayed = 1'b0; @(posedge clk); #1; end
        n_checks++; if (stayed !== 1'b1) begin n_errors++; $display("FAIL start_abort_idle: got busy seen=%b want stayed=1", ~stayed); end
        n_checks++; if ({table_a, pass_a} !== {e.tbl, e.pss}) begin n_errors++; $display("FAIL start_abort_keep: got %h want %h", {table_a, pass_a}, {e.tbl, e.pss}); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] obs; int edges; exp_t e;
        mode_a = 0;
        for (int i = 0; i < 8; i++) obs[i] = f_ref(3'(i));
        sb.push_back(mk_exp(obs, 16));
        do_sweep(1'b0, 40, edges);
        e = sb.pop_front();
        n_checks++; if ({edges, table_a} !== {e.lat, e.tbl}) begin n_errors++; $display("FAIL b2b_first: got %0d/%h want %0d/%h", edges, table_a, e.lat, e.tbl); end
        sb.push_back(mk_exp(8'h00, 16));
        @(negedge clk); start_a = 1'b1; mode_a = 1;
        @(posedge clk); #1; start_a = 1'b0;
        n_checks++; if ({busy_a, done_a, pass_a} !== 3'b100) begin n_errors++; $display("FAIL b2b_accept: got %b want 100", {busy_a, done_a, pass_a}); end
        n_checks++; if ({table_a, mask_a, cnt_a} !== 20'h0) begin n_errors++; $display("FAIL b2b_cleared: got %h want 0", {table_a, mask_a, cnt_a}); end
        wait_done(1'b0, 40, edges);
        e = sb.pop_front();
        n_checks++; if (edges !== e.lat) begin n_errors++; $display("FAIL b2b_latency: got %0d want %0d", edges, e.lat); end
        n_checks++; if ({table_a, mask_a, cnt_a, pass_a} !== {e.tbl, e.msk, e.cnt, e.pss}) begin n_errors++; $display("FAIL b2b_result: got %h want %h", {table_a, mask_a, cnt_a, pass_a}, {e.tbl, e.msk, e.cnt, e.pss}); end
        mode_a = 0;
        m_last_x = 7;
    endtask

    task automatic test_reset_mid();
        logic [7:0] obs; int edges; exp_t e;
        mode_a = 0;
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        repeat (4) @(posedge clk);
        #3; rst = 1'b1;
        #1;
        n_checks++; if ({x_a, busy_a, done_a, pass_a} !== 6'b0) begin n_errors++; $display("FAIL midrst_ctrl: got %b want 0", {x_a, busy_a, done_a, pass_a}); end
        n_checks++; if ({table_a, mask_a, cnt_a} !== 20'h0) begin n_errors++; $display("FAIL midrst_results: got %h want 0", {table_a, mask_a, cnt_a}); end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 8; i++) obs[i] = f_ref(3'(i));
        sb.push_back(mk_exp(obs, 16));
        do_sweep(1'b0, 40, edges);
        e = sb.pop_front();
        n_checks++; if (edges !== e.lat) begin n_errors++; $display("FAIL postrst_latency: got %0d want %0d", edges, e.lat); end
        n_checks++; if ({table_a, mask_a, cnt_a, pass_a} !== {e.tbl, e.msk, e.cnt, e.pss}) begin n_errors++; $display("FAIL postrst_result: got %h want %h", {table_a, mask_a, cnt_a, pass_a}, {e.tbl, e.msk, e.cnt, e.pss}); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_correct();
        test_stuck();
        test_settle();
        test_abort();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
